// File: rtl/serial_tx_queue.sv
// Byte queue feeding an LSB-first serial transmitter.
// Each popped byte is sent one bit per write strobe. The ready line from the receiver gates every strobe.
module serial_tx_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clock_1MHz,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       enqueue_in,
    input  logic                       ready_in,
    output logic                       data_out,
    output logic                       write_out,
    output logic                       busy_out,
    output logic                       done_out,
    output logic                       full_out,
    output logic                       empty_out,
    output logic                       overflow_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] shift;
    logic [BIT_W-1:0]  bit_cnt;
    state_t            state;
    logic              pop;
    logic              push;

    // A pop frees a slot on the same edge, so a full queue still accepts a byte then.
    assign pop  = (state == IDLE) && (count != '0);
    assign push = enqueue_in && ((count != CNT_W'(DEPTH)) || pop);

    assign count_out = count;
    assign full_out  = (count == CNT_W'(DEPTH));
    assign empty_out = (count == '0);

    // Queue storage. The contents do not need a reset because the pointers define which entries are valid.
    always_ff @(posedge clock_1MHz) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_out <= 1'b0;
        end else begin
            overflow_out <= enqueue_in && !push;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // GAP always lasts one cycle, so strobes within a byte are at least two cycles apart.
    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            write_out <= 1'b0;
            data_out  <= 1'b0;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
        end else begin
            write_out <= 1'b0;
            done_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        bit_cnt  <= '0;
                        state    <= SEND;
                        busy_out <= 1'b1;
                    end
                end
                SEND: begin
                    if (ready_in) begin
                        write_out <= 1'b1;
                        data_out  <= shift[0];
                        shift     <= shift >> 1;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (bit_cnt == BIT_W'(DATA_W-1)) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        state   <= SEND;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_queue.sv
// Self-checking bench for serial_tx_queue. It uses table vectors, directed corner sequences and a randomized run.
// The randomized run is checked against a byte-queue reference model.
`timescale 1ns/1ps
module tb_serial_tx_queue;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clock;
    logic              rst_n;
    logic [DATA_W-1:0] data_in;
    logic              enqueue_in;
    logic              ready_in;
    logic              data_out;
    logic              write_out;
    logic              busy_out;
    logic              done_out;
    logic              full_out;
    logic              empty_out;
    logic              overflow_out;
    logic [CNT_W-1:0]  count_out;

    serial_tx_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clock_1MHz   (clock),
        .rst          (rst_n),
        .data_in      (data_in),
        .enqueue_in   (enqueue_in),
        .ready_in     (ready_in),
        .data_out     (data_out),
        .write_out    (write_out),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .full_out     (full_out),
        .empty_out    (empty_out),
        .overflow_out (overflow_out),
        .count_out    (count_out)
    );

    initial begin
        clock = 1'b0;
        forever #500 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cyc[$];
    logic strobe_bit[$];
    int done_cyc[$];
    int ovf_total = 0;
    int sb = 0;
    int db = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // The monitor stamps every strobe and done pulse with the number of the edge that produced it.
    always @(negedge clock) begin
        if (rst_n) begin
            if (write_out) begin
                strobe_cyc.push_back(cyc);
                strobe_bit.push_back(data_out);
            end
            if (done_out) done_cyc.push_back(cyc);
            if (overflow_out) ovf_total <= ovf_total + 1;
        end
    end

    typedef struct {
        logic [7:0] data;
        int         stall_after;
        int         stall_len;
        logic [0:7] exp_bits;
        int         exp_first;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic mark();
        sb = strobe_cyc.size();
        db = done_cyc.size();
    endtask

    function automatic int n_strobes();
        return strobe_cyc.size() - sb;
    endfunction

    function automatic logic [7:0] byte_at(input int k);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = strobe_bit[sb + 8*k + i];
        return b;
    endfunction

    task automatic wait_idle(input int budget, input string name);
        int t = 0;
        while (!(empty_out && !busy_out) && t < budget) begin
            tick();
            t++;
        end
        check(name, 32'(t < budget), 1);
    endtask

    task automatic wait_strobes(input int n, input int budget, input string name);
        int t = 0;
        while (n_strobes() < n && t < budget) begin
            tick();
            t++;
        end
        check(name, 32'(t < budget), 1);
    endtask

    task automatic run_vector(input vec_t v);
        int enq_c;
        int t;
        int n;
        int bad_gaps;
        bit stalled;
        logic [0:7] got;
        mark();
        ready_in   = 1'b1;
        data_in    = v.data;
        enqueue_in = 1'b1;
        enq_c      = cyc + 1;
        tick();
        enqueue_in = 1'b0;
        stalled = 1'b0;
        t = 0;
        while ((done_cyc.size() - db) == 0 && t < 300) begin
            if (!stalled && n_strobes() == v.stall_after) begin
                ready_in = 1'b0;
                n = n_strobes();
                repeat (v.stall_len) tick();
                check($sformatf("vec%02h_stall_quiet", v.data), 32'(n_strobes()), 32'(n));
                ready_in = 1'b1;
                stalled  = 1'b1;
            end
            tick();
            t++;
        end
        check($sformatf("vec%02h_done_seen", v.data), 32'(done_cyc.size() - db), 1);
        check($sformatf("vec%02h_strobes", v.data), 32'(n_strobes()), 8);
        if (n_strobes() >= 8) begin
            check($sformatf("vec%02h_first", v.data), 32'(strobe_cyc[sb] - enq_c), 32'(v.exp_first));
            for (int i = 0; i < 8; i++) got[i] = strobe_bit[sb + i];
            check($sformatf("vec%02h_bits", v.data), 32'(got), 32'(v.exp_bits));
            bad_gaps = 0;
            for (int i = 1; i < 8; i++) begin
                if (i == v.stall_after) begin
                    if (strobe_cyc[sb+i] - strobe_cyc[sb+i-1] <= 2) bad_gaps++;
                end else if (strobe_cyc[sb+i] - strobe_cyc[sb+i-1] != 2) begin
                    bad_gaps++;
                end
            end
            check($sformatf("vec%02h_gaps", v.data), 32'(bad_gaps), 0);
            if ((done_cyc.size() - db) > 0)
                check($sformatf("vec%02h_done_time", v.data), 32'(done_cyc[db] - strobe_cyc[sb+7]), 1);
        end
        check($sformatf("vec%02h_busy_end", v.data), 32'(busy_out), 0);
        check($sformatf("vec%02h_empty_end", v.data), 32'(empty_out), 1);
    endtask

    initial begin
        vec_t vecs[4];
        int t;
        int exp_q[$];
        int pushed;
        int done_base;
        int ovf_base;
        int bad_gaps;

        // Expected bits are written in transmission order, which is LSB first.
        vecs[0] = '{8'hA5, 8, 0,  8'b10100101, 2};
        vecs[1] = '{8'h3C, 3, 10, 8'b00111100, 2};
        vecs[2] = '{8'h01, 8, 0,  8'b10000000, 2};
        vecs[3] = '{8'hB2, 5, 4,  8'b01001101, 2};

        rst_n      = 1'b0;
        data_in    = '0;
        enqueue_in = 1'b0;
        ready_in   = 1'b1;
        #1;
        check("rst_write", 32'(write_out), 0);
        check("rst_count", 32'(count_out), 0);
        check("rst_empty", 32'(empty_out), 1);
        check("rst_full", 32'(full_out), 0);
        check("rst_busy", 32'(busy_out), 0);
        check("rst_ovf", 32'(overflow_out), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_vector(vecs[i]);

        // An asynchronous reset must clear the outputs mid-strobe without waiting for a clock edge.
        mark();
        data_in = 8'h55; enqueue_in = 1'b1; tick();
        data_in = 8'h66; tick();
        enqueue_in = 1'b0;
        t = 0;
        while (!write_out && t < 20) begin tick(); t++; end
        check("async_write_seen", 32'(write_out), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_write", 32'(write_out), 0);
        check("async_count", 32'(count_out), 0);
        check("async_empty", 32'(empty_out), 1);
        check("async_busy", 32'(busy_out), 0);
        tick();
        rst_n = 1'b1;
        mark();
        repeat (20) tick();
        check("async_no_strobes", 32'(n_strobes()), 0);

        // Fill the queue behind a stalled byte, then overflow it.
        ready_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(i); enqueue_in = 1'b1; tick();
        end
        check("fill_count7", 32'(count_out), 7);
        check("fill_full7", 32'(full_out), 0);
        data_in = 8'h08; tick();
        check("fill_count8", 32'(count_out), 8);
        check("fill_full8", 32'(full_out), 1);
        data_in = 8'hFF; tick();
        enqueue_in = 1'b0;
        check("ovf_pulse", 32'(overflow_out), 1);
        check("ovf_count", 32'(count_out), 8);
        tick();
        check("ovf_one_cycle", 32'(overflow_out), 0);

        // Push onto a full queue on the edge where the idle FSM pops.
        mark();
        ready_in = 1'b1;
        t = 0;
        while (!done_out && t < 60) begin tick(); t++; end
        check("popedge_done_seen", 32'(done_out), 1);
        data_in = 8'h09; enqueue_in = 1'b1; tick();
        enqueue_in = 1'b0;
        check("popedge_count", 32'(count_out), 8);
        check("popedge_ovf", 32'(overflow_out), 0);
        wait_idle(1500, "fill_drain");
        check("fill_strobes", 32'(n_strobes()), 80);
        if (n_strobes() >= 80)
            for (int k = 0; k < 10; k++) check($sformatf("fill_byte%0d", k), 32'(byte_at(k)), 32'(k));

        // Send two bytes back to back, then repeat and reset partway through the second byte.
        mark();
        data_in = 8'h81; enqueue_in = 1'b1; tick();
        data_in = 8'h7E; tick();
        enqueue_in = 1'b0;
        wait_idle(200, "pair_drain");
        check("pair_strobes", 32'(n_strobes()), 16);
        check("pair_dones", 32'(done_cyc.size() - db), 2);
        if (n_strobes() >= 16) begin
            check("pair_boundary_gap", 32'(strobe_cyc[sb+8] - strobe_cyc[sb+7]), 3);
            check("pair_byte0", 32'(byte_at(0)), 32'h81);
            check("pair_byte1", 32'(byte_at(1)), 32'h7E);
        end
        mark();
        data_in = 8'h81; enqueue_in = 1'b1; tick();
        data_in = 8'h7E; tick();
        enqueue_in = 1'b0;
        wait_strobes(12, 100, "pair_reach12");
        #2 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("pair_rst_dones", 32'(done_cyc.size() - db), 1);
        mark();
        repeat (30) tick();
        check("pair_rst_quiet", 32'(n_strobes()), 0);
        check("pair_rst_count", 32'(count_out), 0);
        check("pair_rst_empty", 32'(empty_out), 1);
        check("pair_rst_busy", 32'(busy_out), 0);

        // Randomized traffic. The model is an ordered list of accepted bytes; enqueues are gated so none is dropped.
        mark();
        exp_q = {};
        pushed = 0;
        done_base = done_cyc.size();
        ovf_base = ovf_total;
        repeat (600) begin
            ready_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && (pushed - (done_cyc.size() - done_base)) < DEPTH) begin
                data_in = 8'($urandom);
                enqueue_in = 1'b1;
                exp_q.push_back(int'(data_in));
                pushed++;
            end else begin
                enqueue_in = 1'b0;
            end
            tick();
        end
        enqueue_in = 1'b0;
        ready_in = 1'b1;
        wait_idle(3000, "rand_drain");
        check("rand_strobes", 32'(n_strobes()), 32'(8 * exp_q.size()));
        check("rand_no_ovf", 32'(ovf_total - ovf_base), 0);
        if (n_strobes() == 8 * exp_q.size()) begin
            for (int k = 0; k < exp_q.size(); k++)
                check($sformatf("rand_byte%0d", k), 32'(byte_at(k)), 32'(exp_q[k]));
            bad_gaps = 0;
            for (int i = 1; i < n_strobes(); i++)
                if (strobe_cyc[sb+i] - strobe_cyc[sb+i-1] < ((i % 8 == 0) ? 3 : 2)) bad_gaps++;
            check("rand_spacing", 32'(bad_gaps), 0);
        end
        check("rand_count_end", 32'(count_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
